// File: rtl/i2s_pkg.sv
// Shared I2S definitions: default word width, channel encoding and the receive FSM states.
package i2s_pkg;

    localparam int I2S_DATA_W = 24;

    typedef enum logic {
        LEFT  = 1'b0,
        RIGHT = 1'b1
    } i2s_chan_t;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        DELAY = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/i2s_rx_shift.sv
// MSB-first deserialiser with bit counter; done flags the edge that shifts in the last bit.
module i2s_rx_shift
    import i2s_pkg::*;
#(
    parameter int DATA_W = I2S_DATA_W
) (
    input  logic              sclk,
    input  logic              rst,
    input  logic              enable,
    input  logic              clear,
    input  logic              sdin,
    output logic [DATA_W-1:0] word,
    output logic              done
);

    localparam int CW = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] shift_r;
    logic [CW-1:0]     cnt_r;
    logic              last_s;

    assign last_s = (cnt_r == CW'(DATA_W - 1));

    // Shift register and bit counter; clear wins so a new word always starts from bit zero
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            shift_r <= {DATA_W{1'b0}};
            cnt_r   <= {CW{1'b0}};
        end else if (clear) begin
            shift_r <= {DATA_W{1'b0}};
            cnt_r   <= {CW{1'b0}};
        end else if (enable) begin
            shift_r <= {shift_r[DATA_W-2:0], sdin};
            cnt_r   <= last_s ? {CW{1'b0}} : cnt_r + CW'(1);
        end else begin
            shift_r <= shift_r;
            cnt_r   <= cnt_r;
        end
    end

    assign word = shift_r;
    assign done = enable && last_s;

endmodule

// File: rtl/i2s_receiver.sv
// I2S receiver: lrclk-framed capture, left/right pairing and valid/ready output with overrun flag.
// Optional: define I2S_RX_OVERRUN_CNT_EN for an 8-bit saturating dropped-pair counter (overrun_cnt).
module i2s_receiver
    import i2s_pkg::*;
#(
    parameter int DATA_W    = I2S_DATA_W,
    parameter int MSB_DELAY = 2
) (
    input  logic              sclk,
    input  logic              rst,
    input  logic              lrclk,
    input  logic              sdin,
    output logic [DATA_W-1:0] left_data,
    output logic [DATA_W-1:0] right_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overrun,
    input  logic              overrun_clr,
`ifdef I2S_RX_OVERRUN_CNT_EN
    output logic [7:0]        overrun_cnt,
`endif
    output logic              frame_err
);

    localparam rx_state_t START_ST = (MSB_DELAY == 1) ? SHIFT : DELAY;

    rx_state_t         state_r, state_nxt_s;
    logic              lrclk_d_r;
    logic              trans_s;
    logic [7:0]        dly_cnt_r;
    i2s_chan_t         chan_r;
    logic              frame_err_r;
    logic              word_done_r;
    logic              shift_en_s;
    logic [DATA_W-1:0] word_s;
    logic              done_s;
    logic [DATA_W-1:0] shadow_r;
    logic              left_pending_r;
    logic              pair_s, load_s, drop_s;
    logic [DATA_W-1:0] left_data_r, right_data_r;
    logic              out_valid_r, overrun_r;

    assign trans_s    = lrclk ^ lrclk_d_r;
    assign shift_en_s = (state_r == SHIFT) && !trans_s;

    i2s_rx_shift #(.DATA_W(DATA_W)) u_shift (
        .sclk   (sclk),
        .rst    (rst),
        .enable (shift_en_s),
        .clear  (trans_s),
        .sdin   (sdin),
        .word   (word_s),
        .done   (done_s)
    );

    // Next-state logic: any detected transition restarts framing for the new channel
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            SYNC, HOLD: begin
                if (trans_s) state_nxt_s = START_ST;
                else         state_nxt_s = state_r;
            end
            DELAY: begin
                if (trans_s)                                 state_nxt_s = START_ST;
                else if (dly_cnt_r == 8'(MSB_DELAY - 2))     state_nxt_s = SHIFT;
                else                                         state_nxt_s = DELAY;
            end
            SHIFT: begin
                if (trans_s)     state_nxt_s = START_ST;
                else if (done_s) state_nxt_s = HOLD;
                else             state_nxt_s = SHIFT;
            end
            default: state_nxt_s = SYNC;
        endcase
    end

    // Framing registers: state, lrclk history, MSB delay count, channel, truncation pulse
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state_r     <= SYNC;
            lrclk_d_r   <= 1'b0;
            dly_cnt_r   <= 8'd0;
            chan_r      <= LEFT;
            frame_err_r <= 1'b0;
            word_done_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            lrclk_d_r   <= lrclk;
            dly_cnt_r   <= trans_s ? 8'd0 : ((state_r == DELAY) ? dly_cnt_r + 8'd1 : dly_cnt_r);
            chan_r      <= trans_s ? i2s_chan_t'(lrclk) : chan_r;
            frame_err_r <= trans_s && ((state_r == DELAY) || (state_r == SHIFT));
            word_done_r <= done_s;
        end
    end

    // A right word only pairs with a left word completed since the previous pair
    assign pair_s = word_done_r && (chan_r == RIGHT) && left_pending_r;
    assign load_s = pair_s && (!out_valid_r || out_ready);
    assign drop_s = pair_s && out_valid_r && !out_ready;

    // Left shadow and pending flag
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            shadow_r       <= {DATA_W{1'b0}};
            left_pending_r <= 1'b0;
        end else if (word_done_r && (chan_r == LEFT)) begin
            shadow_r       <= word_s;
            left_pending_r <= 1'b1;
        end else if (pair_s) begin
            shadow_r       <= shadow_r;
            left_pending_r <= 1'b0;
        end else begin
            shadow_r       <= shadow_r;
            left_pending_r <= left_pending_r;
        end
    end

    // Output handshake: data only changes on a load, overrun set has priority over clear
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            left_data_r  <= {DATA_W{1'b0}};
            right_data_r <= {DATA_W{1'b0}};
            out_valid_r  <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            if (load_s) begin
                left_data_r  <= shadow_r;
                right_data_r <= word_s;
                out_valid_r  <= 1'b1;
            end else if (out_ready) begin
                out_valid_r  <= 1'b0;
            end else begin
                out_valid_r  <= out_valid_r;
            end
            if (drop_s)           overrun_r <= 1'b1;
            else if (overrun_clr) overrun_r <= 1'b0;
            else                  overrun_r <= overrun_r;
        end
    end

`ifdef I2S_RX_OVERRUN_CNT_EN
    logic [7:0] ovr_cnt_r;

    // Saturating dropped-pair counter; an increment beats a clear on the same edge
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            ovr_cnt_r <= 8'd0;
        end else if (drop_s) begin
            ovr_cnt_r <= (ovr_cnt_r == 8'hFF) ? ovr_cnt_r : ovr_cnt_r + 8'd1;
        end else if (overrun_clr) begin
            ovr_cnt_r <= 8'd0;
        end else begin
            ovr_cnt_r <= ovr_cnt_r;
        end
    end

    assign overrun_cnt = ovr_cnt_r;
`endif

    assign left_data  = left_data_r;
    assign right_data = right_data_r;
    assign out_valid  = out_valid_r;
    assign overrun    = overrun_r;
    assign frame_err  = frame_err_r;

endmodule

// File: doc/i2s_receiver.md
I2S_RECEIVER -- requirements
Module: i2s_receiver

Interface
REQ-001 Parameter DATA_W, default 24: bits captured per channel word.
REQ-002 Parameter MSB_DELAY, default 2: sclk rising edges from the edge that detects an lrclk transition to the edge that samples the MSB.
REQ-003 sclk  input  1  bit clock; the only clock; all logic on posedge sclk.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 lrclk  input  1  word select, synchronous to sclk; 0 = left, 1 = right.
REQ-006 sdin  input  1  serial data, MSB first.
REQ-007 left_data  output  DATA_W  left sample of the presented pair.
REQ-008 right_data  output  DATA_W  right sample of the presented pair.
REQ-009 out_valid  output  1  pair available.
REQ-010 out_ready  input  1  consumer accepts the pair.
REQ-011 overrun  output  1  sticky flag: a completed pair was dropped.
REQ-012 overrun_clr  input  1  clears overrun.
REQ-013 frame_err  output  1  one-cycle pulse: a word was truncated.

Function
REQ-014 The block SHALL register lrclk each cycle (lrclk_d); a transition is detected on the edge where lrclk != lrclk_d.
REQ-015 The FSM SHALL have the states SYNC, DELAY, SHIFT and HOLD; SYNC is entered after reset.
REQ-016 SYNC SHALL go to DELAY on a detected transition; the new channel = current lrclk.
REQ-017 DELAY SHALL wait MSB_DELAY-1 edges, then go to SHIFT; MSB_DELAY=1 samples the MSB on the edge after detection.
REQ-018 SHIFT SHALL shift sdin into a DATA_W register MSB-first, one bit per edge, and go to HOLD after DATA_W bits; the word is then complete.
REQ-019 HOLD SHALL ignore sdin and go to DELAY on the next transition.
REQ-020 A transition detected in DELAY or SHIFT SHALL discard the partial word, pulse frame_err for one cycle, and restart DELAY for the new channel.
REQ-021 A completed left word SHALL be stored in a shadow register.
REQ-022 A completed right word SHALL form a pair only if a left word completed since the last pair; otherwise it SHALL be discarded silently.
REQ-023 A pair completion SHALL load left_data/right_data and set out_valid on the next edge (1-cycle latency) when out_valid=0, or when out_valid=1 and out_ready=1 on that same edge.
REQ-024 When out_valid=1 and out_ready=0 at pair completion, the new pair SHALL be dropped, outputs SHALL be unchanged, and overrun SHALL set.
REQ-025 out_valid SHALL clear on an edge with out_ready=1 unless a new pair loads on that edge.
REQ-026 left_data/right_data SHALL be stable while out_valid=1 and out_ready=0.
REQ-027 overrun_clr and an overrun event on the same edge: overrun SHALL be 1 (set wins).

Reset
REQ-028 While rst=1: state=SYNC, all outputs 0, shift/shadow/counters 0, lrclk_d=0, left-pending cleared.
REQ-029 Reset asserted mid-word SHALL discard the word; after release, no capture occurs before a detected lrclk transition.

Configuration
REQ-030 With I2S_RX_OVERRUN_CNT_EN defined, an output overrun_cnt (8 bits) SHALL count dropped pairs, saturate at 255, clear on overrun_clr (increment wins on the same edge), and reset to 0.
REQ-031 Without I2S_RX_OVERRUN_CNT_EN, neither the port nor the counter SHALL exist; all other behaviour is identical.

Structure
REQ-032 Package i2s_pkg SHALL hold the DATA_W default constant, the channel typedef (LEFT=0, RIGHT=1) and the rx FSM state enum, shared with the transmitter.
REQ-033 Sub-module i2s_rx_shift SHALL contain the shift register and bit counter (inputs: enable, clear, sdin; outputs: word, done); the FSM and handshake stay in i2s_receiver.

Verification
REQ-034 Transmitter loopback, left=24'hA5A5A5, right=24'h123456, out_ready=1 -> out_valid pulses one cycle with exactly those values, frame_err=0.
REQ-035 Hold out_ready=0 across two frames -> first pair held stable, overrun=1, overrun_cnt=1 (macro on); overrun_clr -> overrun=0.
REQ-036 Toggle lrclk after 10 bits of the left word -> frame_err pulses one cycle, no pair output; next full frame outputs correctly.
REQ-037 Release reset with lrclk=1 mid right word -> first right word discarded; first out_valid carries the next complete left+right pair.
REQ-038 Assert rst during the SHIFT of a right word -> all outputs 0 immediately; no pair containing the partial word is ever output.
REQ-039 out_ready=1 on the same edge as a new pair completion while out_valid=1 -> new pair loads, out_valid stays 1, overrun stays 0.
